// File: rtl/naive_dot_unit.sv
// Baseline signed dot-product engine: multiply, 8-wide adder tree, final reduction.
// Three register stages; one result per accepted vector pair, fixed 3-cycle latency.
module naive_dot_unit #(
  parameter int N            = 128,
  parameter int WEIGHT_WIDTH = 4,
  parameter int ACT_WIDTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [N*WEIGHT_WIDTH-1:0]   i_weights_flat,
  input  logic [N*ACT_WIDTH-1:0]      i_acts_flat,
  output logic                        done,
  output logic [15:0]                 result
);

  localparam int unsigned NU  = N;
  localparam int unsigned PW  = WEIGHT_WIDTH + ACT_WIDTH;
  localparam int unsigned NG  = (NU + 7) / 8;
  localparam int unsigned PPW = PW + 3;

  logic signed [PW-1:0]  prod_d [NU];
  logic signed [PW-1:0]  prod_q [NU];
  logic signed [PW-1:0]  prod_pad [NG*8];
  logic signed [PPW-1:0] part_d [NG];
  logic signed [PPW-1:0] part_q [NG];
  logic [15:0]           final_sum;
  logic                  s1_valid;
  logic                  s2_valid;

  // S1 products
  always_comb begin
    for (int unsigned i = 0; i < NU; i++) begin
      prod_d[i] = PW'($signed(i_weights_flat[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]))
                * PW'($signed(i_acts_flat[i*ACT_WIDTH +: ACT_WIDTH]));
    end
  end

  // Pad the tree to a whole number of 8-leaf groups with zero leaves
  always_comb begin
    for (int unsigned i = 0; i < NG*8; i++) begin
      prod_pad[i] = '0;
    end
    for (int unsigned i = 0; i < NU; i++) begin
      prod_pad[i] = prod_q[i];
    end
  end

  always_comb begin
    for (int unsigned g = 0; g < NG; g++) begin
      part_d[g] = '0;
      for (int unsigned j = 0; j < 8; j++) begin
        part_d[g] = part_d[g] + PPW'(prod_pad[g*8 + j]);
      end
    end
  end

  // Low 16 bits of the exact sum: each partial is sign-extended or truncated to
  // 16 bits first, which is equivalent modulo 2^16.
  always_comb begin
    final_sum = '0;
    for (int unsigned g = 0; g < NG; g++) begin
      final_sum = final_sum + 16'(part_q[g]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      for (int unsigned i = 0; i < NU; i++) begin
        prod_q[i] <= '0;
      end
      for (int unsigned g = 0; g < NG; g++) begin
        part_q[g] <= '0;
      end
    end else begin
      s1_valid <= start;
      s2_valid <= s1_valid;
      done     <= s2_valid;
      for (int unsigned i = 0; i < NU; i++) begin
        prod_q[i] <= prod_d[i];
      end
      for (int unsigned g = 0; g < NG; g++) begin
        part_q[g] <= part_d[g];
      end
      if (s2_valid) begin
        result <= final_sum;
      end
    end
  end

endmodule

// File: tb/tb_naive_dot_unit.sv
// Self-checking bench for naive_dot_unit: directed corners plus random streaming
// against a queue-based model of expected results keyed by output cycle.
module tb_naive_dot_unit;

  localparam int N  = 128;
  localparam int WW = 4;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [N*WW-1:0]   i_weights_flat = '0;
  logic [N*AW-1:0]   i_acts_flat = '0;
  logic              done;
  logic [15:0]       result;

  naive_dot_unit #(.N(N), .WEIGHT_WIDTH(WW), .ACT_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .i_weights_flat(i_weights_flat),
    .i_acts_flat(i_acts_flat),
    .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] val;
  } exp_t;

  exp_t        q[$];
  int          cur_w[N];
  int          cur_a[N];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] last_res = '0;

  function automatic logic [15:0] model_dot();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += cur_w[i] * cur_a[i];
    return s[15:0];
  endfunction

  task automatic set_rand();
    for (int i = 0; i < N; i++) begin
      cur_w[i] = int'($urandom_range(15)) - 8;
      cur_a[i] = int'($urandom_range(15)) - 8;
    end
  endtask

  task automatic set_const(input int wv, input int av);
    for (int i = 0; i < N; i++) begin
      cur_w[i] = wv;
      cur_a[i] = av;
    end
  endtask

  // One clock: drive, advance model at the edge, check outputs #1 later.
  task automatic step(input logic rv, input logic st);
    logic        exp_done;
    logic [15:0] exp_res;
    rst   = rv;
    start = st;
    for (int i = 0; i < N; i++) begin
      i_weights_flat[i*WW +: WW] = cur_w[i][WW-1:0];
      i_acts_flat[i*AW +: AW]    = cur_a[i][AW-1:0];
    end
    @(posedge clk);
    cyc++;
    if (!rv) begin
      q.delete();
      last_res = '0;
    end else if (st) begin
      q.push_back('{due: cyc + 2, val: model_dot()});
    end
    #1;
    exp_done = (q.size() > 0) && (q[0].due == cyc);
    exp_res  = exp_done ? q[0].val : last_res;
    if (exp_done) begin
      last_res = q[0].val;
      void'(q.pop_front());
    end
    n_checks++;
    assert (done === exp_done) else begin
      n_fail++;
      $error("FAIL done cyc=%0d observed=%b expected=%b", cyc, done, exp_done);
    end
    n_checks++;
    assert (result === exp_res) else begin
      n_fail++;
      $error("FAIL result cyc=%0d observed=%0d expected=%0d", cyc,
             $signed(result), $signed(exp_res));
    end
  endtask

  // Single vector followed by bubbles; also pins the value to a hand-derived constant.
  task automatic single(input string tag, input logic [15:0] lit);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    n_checks++;
    assert (done === 1'b1 && result === lit) else begin
      n_fail++;
      $error("FAIL %s observed=%0d/done=%b expected=%0d/done=1", tag,
             $signed(result), done, $signed(lit));
    end
    step(1'b1, 1'b0);
  endtask

  initial begin
    // Reset held with start=1 and random data, then release with start=0
    for (int k = 0; k < 5; k++) begin
      set_rand();
      step(1'b0, 1'b1);
    end
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0);

    set_const(0, 0);   single("zero", 16'd0);
    set_const(7, 7);   single("max_pos", 16'd6272);
    set_const(-8, -8); single("neg_neg", 16'd8192);
    set_const(-8, 7);  single("neg_pos", 16'hE400);
    set_const(0, 0);
    cur_w[5] = 1;
    cur_a[5] = 1;
    single("one_hot5", 16'd1);

    for (int i = 0; i < N; i++) begin
      cur_w[i] = (i % 2 == 0) ? 7 : -7;
      cur_a[i] = 7;
    end
    single("alt_sign", 16'd0);
    for (int i = 0; i < N; i++) begin
      cur_w[i] = (i % 16 < 8) ? (i % 16) : (i % 16) - 16;
      cur_a[i] = 1;
    end
    single("nibble_ramp", 16'hFFC0);

    // Streaming back-to-back
    for (int k = 0; k < 1024; k++) begin
      set_rand();
      step(1'b1, 1'b1);
    end
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);

    // Bubble pattern
    begin
      logic pat [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 7; k++) begin
        set_rand();
        step(1'b1, pat[k]);
      end
    end
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);

    // Reset with two vectors in flight
    set_rand(); step(1'b1, 1'b1);
    set_rand(); step(1'b1, 1'b1);
    set_rand(); step(1'b0, 1'b1);
    set_rand(); step(1'b1, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0);

    // Random start pattern mixed in
    for (int k = 0; k < 200; k++) begin
      set_rand();
      step(1'b1, 1'($urandom_range(1)));
    end
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/naive_dot_unit.md
# naive_dot_unit

Fully pipelined signed dot-product engine. Each cycle it can accept one vector pair of N weights and N activations and produce their 16-bit signed inner product a fixed number of cycles later. It is the baseline ("naive", direct multiply-and-add-tree) datapath, used as the reference point against optimized dot-product blocks.

## Interface
Parameters:
- N, 128, number of element pairs per dot product.
- WEIGHT_WIDTH, 4, bits per weight element, signed two's complement.
- ACT_WIDTH, 4, bits per activation element, signed two's complement.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset, synchronous and active-low.
- start  input  1  input-valid; when 1 at a rising edge, the current vectors are accepted.
- i_weights_flat  input  N*WEIGHT_WIDTH  weight vector; element i at bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- i_acts_flat  input  N*ACT_WIDTH  activation vector; element i at bits [i*ACT_WIDTH +: ACT_WIDTH].
- done  output  1  result-valid, one cycle per accepted vector pair.
- result  output  16  signed dot product, valid when done=1.

## Operation
- result = sum over i=0..N-1 of signed(w[i]) * signed(a[i]).
- Product width WEIGHT_WIDTH+ACT_WIDTH, signed; accumulate in a sum wide enough to be exact (product width + clog2(N)); result is the low 16 bits of the exact sum, sign-extended if the exact sum is narrower. Defaults never overflow (range -7168..+8192).
- No backpressure, no busy state: start may be held high continuously; one result per accepted input, strictly in order.
- Datapath is three register stages:
  - S1: N products registered, plus valid bit = start.
  - S2: adder tree reduces products to partial sums (groups of 8; 16 partials for N=128), registered with valid.
  - S3: partials summed to final value, registered into result; done = S2 valid.
- Non-power-of-two N or N not a multiple of 8: missing tree leaves are zero.
- Cycles with start=0 enter a bubble; done=0 for the corresponding output cycle.
- When done=0, result holds its last value (not cleared).

## Timing
- Reset (rst=0 at a rising edge): all valid bits cleared, done=0, result=0, all pipeline data registers cleared. In-flight vectors are discarded; no done pulse ever emerges for them.
- First edge with rst=1 may accept an input (start sampled normally).
- Latency: inputs sampled at edge k → done=1 and result valid after edge k+2, sampled by consumers at edge k+3. Fixed 3-cycle latency regardless of data.
- Throughput: 1 result/cycle; M consecutive start cycles yield exactly M consecutive done cycles.
- Inputs need only be stable around the sampling edge; no input is retained beyond S1.
- start high during reset is ignored.

## Test plan
- Reset: hold rst=0 five cycles with start=1 and random data → done=0, result=0 throughout and for 3 cycles after release with start=0.
- Corner values, single vectors: all w=0,a=0 → 0; all w=7,a=7 → 6272; all w=-8,a=-8 → 8192; all w=-8,a=7 → -7168; w[i]=1,a[i]=1 only i=5 → 1. Each done exactly 3 cycles after sampling.
- Streaming: 1024 back-to-back random vector pairs with start=1 continuously → 1024 consecutive done pulses, each result matching a software signed dot-product model in order.
- Bubbles: start pattern 1,0,1,1,0,0,1 → done pattern identical, delayed 3 cycles; result holds value during done=0 cycles.
- Reset mid-stream: assert rst=0 one cycle while 2 vectors are in flight → those produce no done; next accepted vector returns correct result with 3-cycle latency.
- Alternating signs: w[i]=(-1)^i*7, a[i]=7 → 0; w[i]=i%16 as signed nibble, a=1 → 128*(-8+...+7)/16 sum = -64.
